pipe_hazard_ctrl: RTL and testbench

//  Sequencer for the IF/ID and ID/EX pipeline registers of the 5-stage core.
//  - Detects load-use and, optionally, plain RAW hazards; drives stalls, bubbles and flushes.
//  - Holds the front end while a multi-cycle MDU op occupies EX.
//  - Sits between the decode stage, the hazard-source pipeline registers and the PC/IF-ID/ID-EX enables.

---
 rtl/pipe_pkg.sv | 16 +
 rtl/haz_cmp.sv | 28 ++
 rtl/pipe_hazard_ctrl.sv | 159 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and widths for the pipeline hazard controller
// Contents: sequencer state enum, register-address width, ID/EX control-field widths.
package pipe_pkg;

    localparam int RA_W = 5;
    localparam int WB_W = 2;
    localparam int M_W  = 3;
    localparam int EX_W = 4;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MDU_WAIT = 2'd2
    } state_e;

endpackage

// File: rtl/haz_cmp.sv
// rtl/haz_cmp.sv - source-register vs destination comparator with r0 masking
// Ports:
//   rs, rt          in  source registers of the instruction in ID
//   use_rs, use_rt  in  ID instruction actually reads rs / rt
//   dest            in  destination register of the producing stage
//   regwrite        in  producing stage writes a register
//   hit             out either used source matches a live, non-zero destination
module haz_cmp #(
    parameter int RA_W = pipe_pkg::RA_W
) (
    input  logic [RA_W-1:0] rs,
    input  logic [RA_W-1:0] rt,
    input  logic            use_rs,
    input  logic            use_rt,
    input  logic [RA_W-1:0] dest,
    input  logic            regwrite,
    output logic            hit
);

    logic hit_rs;
    logic hit_rt;

    // r0 is hard-wired to zero, so a write to it never produces a real dependency.
    assign hit_rs = use_rs & (rs != '0) & (rs == dest) & regwrite;
    assign hit_rt = use_rt & (rt != '0) & (rt == dest) & regwrite;
    assign hit    = hit_rs | hit_rt;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - IF/ID and ID/EX sequencer: load-use/RAW stalls, branch flush, MDU hold
// Configuration macro: HAZ_FORWARD_EN (defined: forwarding present, only load-use stalls;
//   undefined: every RAW match against EX or MEM stalls and LU_STALL is never entered).
// Ports:
//   clock, reset                      clock and asynchronous active-high reset
//   id_rs/id_rt/id_use_rs/id_use_rt   source operands of the ID instruction
//   id_mdu                            ID instruction is a multi-cycle MDU op
//   idex_memread/regwrite/rd          load flag, write flag and destination in EX
//   exmem_regwrite/rd                 write flag and destination in MEM
//   ex_br_taken                       branch/jump resolved taken in EX
//   pc_write, ifid_write              PC and IF/ID load enables
//   ifid_flush, idex_bubble           IF/ID to NOP, ID/EX control fields to zero
//   idex_hold                         ID/EX keeps its contents while the MDU runs
//   busy                              sequencer is not in RUN
//   stall_cnt                         saturating count of cycles with pc_write low
module pipe_hazard_ctrl #(
    parameter int MDU_LAT = 4,
    parameter int CNT_W   = 16,
    parameter int RA_W    = pipe_pkg::RA_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [RA_W-1:0]  id_rs,
    input  logic [RA_W-1:0]  id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             id_mdu,
    input  logic             idex_memread,
    input  logic             idex_regwrite,
    input  logic [RA_W-1:0]  idex_rd,
    input  logic             exmem_regwrite,
    input  logic [RA_W-1:0]  exmem_rd,
    input  logic             ex_br_taken,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_hold,
    output logic             idex_bubble,
    output logic             busy,
    output logic [CNT_W-1:0] stall_cnt
);

    import pipe_pkg::*;

    localparam int              MC_W     = $clog2(MDU_LAT + 1);
    localparam logic [MC_W-1:0] MDU_LOAD = MC_W'(MDU_LAT - 1);

    state_e           state_q, state_d;
    logic [MC_W-1:0]  mdu_cnt_q, mdu_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic ex_hit;
    logic mem_hit;
    logic stall_haz;
    logic pc_c, ifw_c, flush_c, hold_c, bubble_c;

    haz_cmp #(.RA_W(RA_W)) u_ex_cmp (
        .rs       (id_rs),
        .rt       (id_rt),
        .use_rs   (id_use_rs),
        .use_rt   (id_use_rt),
        .dest     (idex_rd),
        .regwrite (idex_regwrite),
        .hit      (ex_hit)
    );

    haz_cmp #(.RA_W(RA_W)) u_mem_cmp (
        .rs       (id_rs),
        .rt       (id_rt),
        .use_rs   (id_use_rs),
        .use_rt   (id_use_rt),
        .dest     (exmem_rd),
        .regwrite (exmem_regwrite),
        .hit      (mem_hit)
    );

`ifdef HAZ_FORWARD_EN
    // Forwarding covers everything except a load whose data is not back until MEM ends.
    localparam state_e HAZ_NEXT = LU_STALL;
    logic unused_mem_hit;
    assign unused_mem_hit = mem_hit;
    assign stall_haz      = idex_memread & ex_hit;
`else
    // No forwarding: the consumer waits in ID until no producer is left in EX or MEM.
    localparam state_e HAZ_NEXT = RUN;
    logic unused_memread;
    assign unused_memread = idex_memread;
    assign stall_haz      = ex_hit | mem_hit;
`endif

    always_comb begin
        pc_c      = 1'b1;
        ifw_c     = 1'b1;
        flush_c   = 1'b0;
        hold_c    = 1'b0;
        bubble_c  = 1'b0;
        state_d   = state_q;
        mdu_cnt_d = mdu_cnt_q;
        case (state_q)
            RUN, LU_STALL: begin
                // The LU_STALL cycle issues the dependent instruction exactly like RUN.
                if (ex_br_taken) begin
                    flush_c  = 1'b1;
                    bubble_c = 1'b1;
                    state_d  = RUN;
                end else if (stall_haz) begin
                    pc_c     = 1'b0;
                    ifw_c    = 1'b0;
                    bubble_c = 1'b1;
                    state_d  = HAZ_NEXT;
                end else if (id_mdu) begin
                    state_d   = MDU_WAIT;
                    mdu_cnt_d = MDU_LOAD;
                end else begin
                    state_d = RUN;
                end
            end
            MDU_WAIT: begin
                // The MDU op owns EX; a taken branch cannot be in EX here.
                pc_c      = 1'b0;
                ifw_c     = 1'b0;
                hold_c    = 1'b1;
                mdu_cnt_d = mdu_cnt_q - MC_W'(1);
                if (mdu_cnt_q == MC_W'(1)) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
        stall_cnt_d = stall_cnt_q;
        if (!pc_c && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= RUN;
            mdu_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            mdu_cnt_q   <= mdu_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Reset forces the free-running enables on regardless of what decode presents.
    assign pc_write    = reset | pc_c;
    assign ifid_write  = reset | ifw_c;
    assign ifid_flush  = ~reset & flush_c;
    assign idex_hold   = ~reset & hold_c;
    assign idex_bubble = ~reset & bubble_c;
    assign busy        = ~reset & (state_q != RUN);
    assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       urs;
        logic       urt;
        logic       mdu;
        logic       ld;
        logic       exw;
        logic [4:0] exrd;
        logic       mw;
        logic [4:0] mrd;
        logic       br;
    } stim_t;

    // flags = {pc_write, ifid_write, ifid_flush, idex_hold, idex_bubble, busy}
    localparam logic [5:0] NORM    = 6'b110000;
    localparam logic [5:0] ISSUE_B = 6'b110001;
    localparam logic [5:0] STALL   = 6'b000010;
    localparam logic [5:0] STALL_B = 6'b000011;
    localparam logic [5:0] FLUSH   = 6'b111010;
    localparam logic [5:0] FLUSH_B = 6'b111011;
    localparam logic [5:0] MWAIT   = 6'b000101;

    logic       clock;
    logic       reset;
    logic [4:0] id_rs, id_rt, idex_rd, exmem_rd;
    logic       id_use_rs, id_use_rt, id_mdu, idex_memread, idex_regwrite;
    logic       exmem_regwrite, ex_br_taken;
    logic       pc_write, ifid_write, ifid_flush, idex_hold, idex_bubble, busy;
    logic [7:0] stall_cnt;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  exp_stall = 8'h00;
    logic [13:0] sb[$];

    pipe_hazard_ctrl #(.MDU_LAT(4), .CNT_W(8), .RA_W(5)) dut (
        .clock          (clock),
        .reset          (reset),
        .id_rs          (id_rs),
        .id_rt          (id_rt),
        .id_use_rs      (id_use_rs),
        .id_use_rt      (id_use_rt),
        .id_mdu         (id_mdu),
        .idex_memread   (idex_memread),
        .idex_regwrite  (idex_regwrite),
        .idex_rd        (idex_rd),
        .exmem_regwrite (exmem_regwrite),
        .exmem_rd       (exmem_rd),
        .ex_br_taken    (ex_br_taken),
        .pc_write       (pc_write),
        .ifid_write     (ifid_write),
        .ifid_flush     (ifid_flush),
        .idex_hold      (idex_hold),
        .idex_bubble    (idex_bubble),
        .busy           (busy),
        .stall_cnt      (stall_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic stim_t mk(int rs, int rt, int urs, int urt, int mdu, int ld,
                                 int exw, int exrd, int mw, int mrd, int br);
        stim_t s;
        s.rs = 5'(rs);   s.rt = 5'(rt);
        s.urs = 1'(urs); s.urt = 1'(urt);
        s.mdu = 1'(mdu); s.ld = 1'(ld);
        s.exw = 1'(exw); s.exrd = 5'(exrd);
        s.mw = 1'(mw);   s.mrd = 5'(mrd);
        s.br = 1'(br);
        return s;
    endfunction

    task automatic drive(input stim_t s);
        id_rs = s.rs; id_rt = s.rt; id_use_rs = s.urs; id_use_rt = s.urt;
        id_mdu = s.mdu; idex_memread = s.ld; idex_regwrite = s.exw; idex_rd = s.exrd;
        exmem_regwrite = s.mw; exmem_rd = s.mrd; ex_br_taken = s.br;
    endtask

    function automatic logic [13:0] observe();
        return {pc_write, ifid_write, ifid_flush, idex_hold, idex_bubble, busy, stall_cnt};
    endfunction

    task automatic test_reset();
        logic [13:0] got;
        reset = 1'b1;
        drive(mk(2, 0, 1, 0, 1, 1, 1, 2, 1, 2, 1));
        #2;
        got = observe();
        checks++;
        if (got !== {NORM, 8'h00}) begin
            errors++;
            $display("FAIL reset_outputs: got flags=%b cnt=%0d, expected flags=%b cnt=0", got[13:8], got[7:0], NORM);
        end
        repeat (2) @(posedge clock);
        #1;
        got = observe();
        checks++;
        if (got !== {NORM, 8'h00}) begin
            errors++;
            $display("FAIL reset_held: got flags=%b cnt=%0d, expected flags=%b cnt=0", got[13:8], got[7:0], NORM);
        end
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clock);
        #1 reset = 1'b0;
        exp_stall = 8'h00;
    endtask

    task automatic test_load_use();
        stim_t st[$];
        logic [5:0] ef[$];
        logic [13:0] got, want;
        st = '{mk(2, 0, 1, 0, 0, 1, 1, 2, 0, 0, 0),
               mk(2, 0, 1, 0, 0, 0, 0, 0, 1, 2, 0),
               mk(2, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0)};
`ifdef HAZ_FORWARD_EN
        ef = '{STALL, ISSUE_B, NORM};
`else
        ef = '{STALL, STALL, NORM};
`endif
        for (int i = 0; i < st.size(); i++) begin
            drive(st[i]);
            sb.push_back({ef[i], exp_stall});
            @(negedge clock);
            got = observe();
            want = sb.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL load_use[%0d]: got flags=%b cnt=%0d, expected flags=%b cnt=%0d", i, got[13:8], got[7:0], want[13:8], want[7:0]);
            end
            if (!want[13] && exp_stall != 8'hFF) exp_stall++;
            @(posedge clock);
            #1;
        end
    endtask

    task automatic test_reg0();
        stim_t st[$];
        logic [13:0] got, want;
        st = '{mk(0, 0, 1, 1, 0, 1, 1, 0, 1, 0, 0),
               mk(0, 3, 0, 0, 0, 1, 1, 3, 1, 3, 0),
               mk(4, 0, 1, 0, 0, 0, 0, 4, 0, 4, 0)};
        for (int i = 0; i < st.size(); i++) begin
            drive(st[i]);
            sb.push_back({NORM, exp_stall});
            @(negedge clock);
            got = observe();
            want = sb.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL reg0_no_hazard[%0d]: got flags=%b cnt=%0d, expected flags=%b cnt=%0d", i, got[13:8], got[7:0], want[13:8], want[7:0]);
            end
            if (!want[13] && exp_stall != 8'hFF) exp_stall++;
            @(posedge clock);
            #1;
        end
    endtask

    task automatic test_branch();
        stim_t st[$];
        logic [5:0] ef[$];
        logic [13:0] got, want;
        st = '{mk(2, 0, 1, 0, 0, 1, 1, 2, 0, 0, 1),
               mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0),
               mk(6, 0, 1, 0, 0, 1, 1, 6, 0, 0, 0),
               mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1),
               mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
`ifdef HAZ_FORWARD_EN
        ef = '{FLUSH, NORM, STALL, FLUSH_B, NORM};
`else
        ef = '{FLUSH, NORM, STALL, FLUSH, NORM};
`endif
        for (int i = 0; i < st.size(); i++) begin
            drive(st[i]);
            sb.push_back({ef[i], exp_stall});
            @(negedge clock);
            got = observe();
            want = sb.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL branch_flush[%0d]: got flags=%b cnt=%0d, expected flags=%b cnt=%0d", i, got[13:8], got[7:0], want[13:8], want[7:0]);
            end
            if (!want[13] && exp_stall != 8'hFF) exp_stall++;
            @(posedge clock);
            #1;
        end
    endtask

    task automatic test_mdu();
        stim_t st[$];
        logic [5:0] ef[$];
        logic [13:0] got, want;
        st = '{mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0),
               mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0),
               mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1),
               mk(2, 0, 1, 0, 0, 1, 1, 2, 0, 0, 0),
               mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0),
               mk(2, 0, 1, 0, 1, 1, 1, 2, 0, 0, 0),
`ifdef HAZ_FORWARD_EN
               mk(2, 0, 1, 0, 1, 0, 0, 0, 1, 2, 0),
`else
               mk(2, 0, 1, 0, 1, 0, 0, 0, 1, 2, 0),
               mk(2, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0),
`endif
               mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0),
               mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0),
               mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0),
               mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
`ifdef HAZ_FORWARD_EN
        ef = '{NORM, MWAIT, MWAIT, MWAIT, NORM, STALL, ISSUE_B, MWAIT, MWAIT, MWAIT, NORM};
`else
        ef = '{NORM, MWAIT, MWAIT, MWAIT, NORM, STALL, STALL, NORM, MWAIT, MWAIT, MWAIT, NORM};
`endif
        for (int i = 0; i < st.size(); i++) begin
            drive(st[i]);
            sb.push_back({ef[i], exp_stall});
            @(negedge clock);
            got = observe();
            want = sb.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL mdu_wait[%0d]: got flags=%b cnt=%0d, expected flags=%b cnt=%0d", i, got[13:8], got[7:0], want[13:8], want[7:0]);
            end
            if (!want[13] && exp_stall != 8'hFF) exp_stall++;
            @(posedge clock);
            #1;
        end
    endtask

    task automatic test_raw();
        stim_t st[$];
        logic [5:0] ef[$];
        logic [13:0] got, want;
        st = '{mk(0, 5, 0, 1, 0, 0, 0, 0, 1, 5, 0),
               mk(0, 5, 0, 1, 0, 0, 0, 0, 1, 5, 0),
               mk(7, 0, 1, 0, 0, 0, 1, 7, 0, 0, 0),
               mk(0, 5, 0, 1, 0, 0, 0, 0, 0, 5, 0)};
`ifdef HAZ_FORWARD_EN
        ef = '{NORM, NORM, NORM, NORM};
`else
        ef = '{STALL, STALL, STALL, NORM};
`endif
        for (int i = 0; i < st.size(); i++) begin
            drive(st[i]);
            sb.push_back({ef[i], exp_stall});
            @(negedge clock);
            got = observe();
            want = sb.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL raw_stall[%0d]: got flags=%b cnt=%0d, expected flags=%b cnt=%0d", i, got[13:8], got[7:0], want[13:8], want[7:0]);
            end
            if (!want[13] && exp_stall != 8'hFF) exp_stall++;
            @(posedge clock);
            #1;
        end
    endtask

    task automatic test_reset_mid_mdu();
        stim_t st[$];
        logic [5:0] ef[$];
        logic [13:0] got, want;
        st = '{mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0),
               mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
        ef = '{NORM, MWAIT};
        for (int i = 0; i < st.size(); i++) begin
            drive(st[i]);
            sb.push_back({ef[i], exp_stall});
            @(negedge clock);
            got = observe();
            want = sb.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL mid_mdu_setup[%0d]: got flags=%b cnt=%0d, expected flags=%b cnt=%0d", i, got[13:8], got[7:0], want[13:8], want[7:0]);
            end
            if (!want[13] && exp_stall != 8'hFF) exp_stall++;
            @(posedge clock);
            #1;
        end
        reset = 1'b1;
        exp_stall = 8'h00;
        #1;
        got = observe();
        checks++;
        if (got !== {NORM, 8'h00}) begin
            errors++;
            $display("FAIL reset_mid_mdu: got flags=%b cnt=%0d, expected flags=%b cnt=0", got[13:8], got[7:0], NORM);
        end
        @(posedge clock);
        #1 reset = 1'b0;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        sb.push_back({NORM, exp_stall});
        @(negedge clock);
        got = observe();
        want = sb.pop_front();
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL after_reset_run: got flags=%b cnt=%0d, expected flags=%b cnt=%0d", got[13:8], got[7:0], want[13:8], want[7:0]);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_saturate();
        logic [13:0] got, want;
        logic [5:0]  f;
        for (int i = 0; i < 271; i++) begin
            if (i < 270) begin
                drive(mk(3, 0, 1, 0, 0, 1, 1, 3, 0, 0, 0));
`ifdef HAZ_FORWARD_EN
                f = (i == 0) ? STALL : STALL_B;
`else
                f = STALL;
`endif
            end else begin
                drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
`ifdef HAZ_FORWARD_EN
                f = ISSUE_B;
`else
                f = NORM;
`endif
            end
            sb.push_back({f, exp_stall});
            @(negedge clock);
            got = observe();
            want = sb.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL saturate[%0d]: got flags=%b cnt=%0d, expected flags=%b cnt=%0d", i, got[13:8], got[7:0], want[13:8], want[7:0]);
            end
            if (!want[13] && exp_stall != 8'hFF) exp_stall++;
            @(posedge clock);
            #1;
        end
        checks++;
        if (stall_cnt !== 8'hFF) begin
            errors++;
            $display("FAIL saturate_final: got cnt=%0d, expected cnt=255", stall_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_reg0();
        test_branch();
        test_mdu();
        test_raw();
        test_reset_mid_mdu();
        test_saturate();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
